// File: rtl/result_checker_pkg.sv
// Shared types and defaults for the result checker scoreboard.
package result_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } checker_state_t;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at its all-ones maximum.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/result_checker.sv
// Compares reference and DUT responses over a fixed-length run and keeps
// sample/mismatch statistics, first-error index and a sticky error-bit mask.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned NUM_SAMPLES = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] q_ref,
    input  logic [WIDTH-1:0] q_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic             first_error_seen,
    output logic [CNT_W-1:0] first_error_idx,
    output logic [WIDTH-1:0] error_bits
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    checker_state_t   state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic             first_seen_q, first_seen_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic [WIDTH-1:0] diff;
    logic             hit;
    logic             accept;
    logic             final_sample;

    // start always wins over a coincident sample, which is then dropped
    always_comb begin
        diff         = q_ref ^ q_dut;
        hit          = |diff;
        accept       = (state_q == RUN) && sample_valid && !start;
        final_sample = accept && (sample_cnt_q == LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (final_sample) begin
            state_d = DONE;
        end
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        first_idx_d  = first_idx_q;
        first_seen_d = first_seen_q;
        mismatch_d   = mismatch_q;
        bits_d       = bits_q;
        if (start) begin
            sample_cnt_d = '0;
            first_idx_d  = '0;
            first_seen_d = 1'b0;
            mismatch_d   = 1'b0;
            bits_d       = '0;
        end else if (accept) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            mismatch_d   = hit;
            if (hit) begin
                bits_d = bits_q | diff;
                if (!first_seen_q) begin
                    first_idx_d  = sample_cnt_q;
                    first_seen_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            first_idx_q  <= '0;
            first_seen_q <= 1'b0;
            mismatch_q   <= 1'b0;
            bits_q       <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            first_idx_q  <= first_idx_d;
            first_seen_q <= first_seen_d;
            mismatch_q   <= mismatch_d;
            bits_q       <= bits_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .inc   (accept && hit),
        .cnt   (error_count)
    );

    always_comb begin
        busy             = (state_q == RUN);
        done             = (state_q == DONE);
        pass             = done && (error_count == '0);
        mismatch         = mismatch_q;
        sample_count     = sample_cnt_q;
        first_error_seen = first_seen_q;
        first_error_idx  = first_idx_q;
        error_bits       = bits_q;
    end

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench: expected end-of-run statistics are queued at stimulus time
// and popped by per-instance monitors whenever done rises.
module tb_result_checker;
    import result_checker_pkg::*;

    typedef struct {
        logic [15:0] sc;
        logic [15:0] ec;
        logic [15:0] fidx;
        logic [3:0]  bits;
        logic        fseen;
        logic        ps;
    } exp_t;

    int errors = 0;
    int checks = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // A: WIDTH=1, default counter width, 8 samples
    logic                     start_a, valid_a, ref_a, dut_a;
    logic                     busy_a, done_a, pass_a, mism_a, fseen_a, bits_a;
    logic [CNT_W_DEFAULT-1:0] sc_a, ec_a, fidx_a;
    // B: WIDTH=4, 5 samples
    logic                     start_b, valid_b;
    logic [3:0]               ref_b, dut_b, bits_b;
    logic                     busy_b, done_b, pass_b, mism_b, fseen_b;
    logic [15:0]              sc_b, ec_b, fidx_b;
    // C: CNT_W=3, 7 samples
    logic                     start_c, valid_c, ref_c, dut_c;
    logic                     busy_c, done_c, pass_c, mism_c, fseen_c, bits_c;
    logic [2:0]               sc_c, ec_c, fidx_c;
    // standalone saturating counter
    logic                     sat_clr, sat_inc;
    logic [2:0]               sat_cnt;

    result_checker #(.WIDTH(1), .CNT_W(CNT_W_DEFAULT), .NUM_SAMPLES(8)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .sample_valid(valid_a),
        .q_ref(ref_a), .q_dut(dut_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .mismatch(mism_a), .sample_count(sc_a), .error_count(ec_a),
        .first_error_seen(fseen_a), .first_error_idx(fidx_a), .error_bits(bits_a)
    );

    result_checker #(.WIDTH(4), .CNT_W(16), .NUM_SAMPLES(5)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .sample_valid(valid_b),
        .q_ref(ref_b), .q_dut(dut_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .mismatch(mism_b), .sample_count(sc_b), .error_count(ec_b),
        .first_error_seen(fseen_b), .first_error_idx(fidx_b), .error_bits(bits_b)
    );

    result_checker #(.WIDTH(1), .CNT_W(3), .NUM_SAMPLES(7)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .sample_valid(valid_c),
        .q_ref(ref_c), .q_dut(dut_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .mismatch(mism_c), .sample_count(sc_c), .error_count(ec_c),
        .first_error_seen(fseen_c), .first_error_idx(fidx_c), .error_bits(bits_c)
    );

    sat_counter #(.W(3)) u_sat (
        .clk(clk), .reset(reset), .clr(sat_clr), .inc(sat_inc), .cnt(sat_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int sc, input int ec, input int fseen, input int fidx,
                                input int bits, input int ps);
        exp_t r;
        r.sc    = 16'(sc);
        r.ec    = 16'(ec);
        r.fseen = 1'(fseen);
        r.fidx  = 16'(fidx);
        r.bits  = 4'(bits);
        r.ps    = 1'(ps);
        return r;
    endfunction

    task automatic cmp_res(input string tag, input exp_t e, input logic [31:0] sc,
                           input logic [31:0] ec, input logic [31:0] fseen,
                           input logic [31:0] fidx, input logic [31:0] bits,
                           input logic [31:0] ps);
        check({tag, "_sample_count"}, sc, 32'(e.sc));
        check({tag, "_error_count"}, ec, 32'(e.ec));
        check({tag, "_first_error_seen"}, fseen, 32'(e.fseen));
        check({tag, "_first_error_idx"}, fidx, 32'(e.fidx));
        check({tag, "_error_bits"}, bits, 32'(e.bits));
        check({tag, "_pass"}, ps, 32'(e.ps));
    endtask

    task automatic unexpected(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: done rose with no expected result queued", tag);
    endtask

    // Monitors: pop one expected result per rising edge of done
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (q_a.size() == 0) unexpected("mon_a");
                else cmp_res("mon_a", q_a.pop_front(), sc_a, ec_a, fseen_a, fidx_a, bits_a, pass_a);
            end
            prev = done_a;
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                if (q_b.size() == 0) unexpected("mon_b");
                else cmp_res("mon_b", q_b.pop_front(), sc_b, ec_b, fseen_b, fidx_b, bits_b, pass_b);
            end
            prev = done_b;
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done_c && !prev) begin
                if (q_c.size() == 0) unexpected("mon_c");
                else cmp_res("mon_c", q_c.pop_front(), sc_c, ec_c, fseen_c, fidx_c, bits_c, pass_c);
            end
            prev = done_c;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic a, b;
        int   k;
        reset   = 1'b0;
        start_a = 0; valid_a = 0; ref_a = 0; dut_a = 0;
        start_b = 0; valid_b = 0; ref_b = 0; dut_b = 0;
        start_c = 0; valid_c = 0; ref_c = 0; dut_c = 0;
        sat_clr = 0; sat_inc = 0;
        #2 reset = 1'b1;
        #10;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_sample_count", sc_b, 0);
        check("rst_error_count", ec_b, 0);
        check("rst_first_seen", fseen_b, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // exhaustive AND sweep, all matching
        start_a = 1; tick(); start_a = 0;
        check("a_busy_after_start", busy_a, 1);
        q_a.push_back(mk(8, 0, 0, 0, 0, 1));
        for (int i = 0; i < 8; i++) begin
            a = i[1]; b = i[0];
            ref_a = a & b; dut_a = a & b; valid_a = 1;
            tick();
        end
        valid_a = 0;
        check("a_done_after_sweep", done_a, 1);
        // samples in DONE are ignored
        valid_a = 1; ref_a = 0; dut_a = 1;
        tick(); tick();
        valid_a = 0;
        check("a_done_ignores_count", sc_a, 8);
        check("a_done_ignores_err", ec_a, 0);

        // injected fault: q_dut = a|b
        start_a = 1; tick(); start_a = 0;
        check("a_restart_clears", sc_a, 0);
        q_a.push_back(mk(8, 4, 1, 1, 1, 0));
        for (int i = 0; i < 8; i++) begin
            a = i[1]; b = i[0];
            ref_a = a & b; dut_a = a | b; valid_a = 1;
            tick();
            check("a_mismatch_flag", mism_a, a ^ b);
        end
        valid_a = 0;

        // gapped valid on B
        start_b = 1; tick(); start_b = 0;
        q_b.push_back(mk(5, 1, 1, 3, 4'b0110, 0));
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                valid_b = 1;
                ref_b = 4'(k * 3 + 1);
                dut_b = (k == 3) ? (ref_b ^ 4'b0110) : ref_b;
                k++;
            end else begin
                valid_b = 0;
            end
            tick();
            if (i == 7) check("b_done_before_last", done_b, 0);
            if (i == 8) check("b_done_after_last", done_b, 1);
        end
        valid_b = 0;

        // restart colliding with a mismatching sample
        start_b = 1; tick(); start_b = 0;
        for (int i = 0; i < 3; i++) begin
            valid_b = 1; ref_b = 4'(i + 2);
            dut_b = (i == 0) ? ref_b : (ref_b ^ 4'b1000);
            tick();
        end
        check("b_pre_collision_err", ec_b, 2);
        start_b = 1; valid_b = 1; ref_b = 4'h0; dut_b = 4'hf;
        tick();
        start_b = 0; valid_b = 0;
        check("b_coll_sample_count", sc_b, 0);
        check("b_coll_error_count", ec_b, 0);
        check("b_coll_first_seen", fseen_b, 0);
        check("b_coll_error_bits", bits_b, 0);
        check("b_coll_mismatch", mism_b, 0);
        check("b_coll_busy", busy_b, 1);
        q_b.push_back(mk(5, 0, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            valid_b = 1; ref_b = 4'(i * 5); dut_b = ref_b;
            tick();
        end
        valid_b = 0;

        // all-mismatch run on 3-bit counters
        start_c = 1; tick(); start_c = 0;
        q_c.push_back(mk(7, 7, 1, 0, 1, 0));
        for (int i = 0; i < 7; i++) begin
            valid_c = 1; ref_c = 0; dut_c = 1;
            tick();
        end
        valid_c = 0;

        // saturating counter holds at maximum
        sat_clr = 1; tick(); sat_clr = 0;
        sat_inc = 1;
        repeat (5) tick();
        check("sat_mid", sat_cnt, 5);
        repeat (5) tick();
        sat_inc = 0;
        check("sat_hold", sat_cnt, 7);

        // asynchronous reset mid-run
        start_a = 1; tick(); start_a = 0;
        valid_a = 1; ref_a = 0; dut_a = 1;
        repeat (3) tick();
        check("a_pre_reset_err", ec_a, 3);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_sample_count", sc_a, 0);
        check("arst_error_count", ec_a, 0);
        check("arst_first_seen", fseen_a, 0);
        check("arst_mismatch", mism_a, 0);
        check("arst_error_bits", bits_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        valid_a = 0;
        check("post_reset_ignored_count", sc_a, 0);
        check("post_reset_ignored_busy", busy_a, 0);
        check("post_reset_ignored_err", ec_a, 0);

        repeat (2) tick();
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        check("queue_c_drained", q_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
